// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt scheduler: FSM state encoding
// and the source-index convention used within each timer's interrupt pair.
package timer_irq_pkg;

  typedef logic [0:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 1'b0;
  localparam sched_state_t ST_OFFER = 1'b1;

  // Within timer k, source 2k is overflow and source 2k+1 is compare.
  localparam int SRC_OVF = 0;
  localparam int SRC_CMP = 1;

endpackage

// File: rtl/timer_irq_rr_pick.sv
// Combinational rotating-priority picker: returns the first set bit of
// elig at or above ptr, wrapping around to index 0.
module timer_irq_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    elig,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] id
);

  int idx;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    found = 1'b0;
    id    = '0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (elig[idx]) begin
        found = 1'b1;
        id    = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/timer_irq_sched.sv
// Timer interrupt scheduler: latches rising edges of the timer interrupt
// lines and offers them round-robin to the event unit over valid/ready.
module timer_irq_sched
  import timer_irq_pkg::*;
#(
  parameter  int TIMER_CNT = 2,
  localparam int SRC_CNT   = 2 * TIMER_CNT,
  localparam int ID_W      = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [SRC_CNT-1:0] irq_i,
  input  logic [SRC_CNT-1:0] mask_i,
  output logic               evt_valid_o,
  output logic [ID_W-1:0]    evt_id_o,
  input  logic               evt_ready_i,
  output logic [SRC_CNT-1:0] pending_o,
  output logic [SRC_CNT-1:0] lost_o,
  input  logic [SRC_CNT-1:0] lost_clr_i
);

  sched_state_t       state_q;
  logic [SRC_CNT-1:0] irq_q;
  logic [SRC_CNT-1:0] pending_q;
  logic [SRC_CNT-1:0] lost_q;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    evt_id_q;

  logic [SRC_CNT-1:0] rise;
  logic [SRC_CNT-1:0] eligible;
  logic [SRC_CNT-1:0] grant_vec;
  logic [SRC_CNT-1:0] pending_d;
  logic [SRC_CNT-1:0] lost_d;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    ptr_next;
  logic               grant;

  timer_irq_rr_pick #(
    .N    (SRC_CNT),
    .ID_W (ID_W)
  ) u_pick (
    .elig  (eligible),
    .ptr   (ptr_q),
    .found (pick_found),
    .id    (pick_id)
  );

  assign rise     = irq_i & ~irq_q;
  assign eligible = pending_q & ~mask_i;

  // A grant happens from IDLE, or in OFFER only on the handshake cycle.
  assign grant     = pick_found && ((state_q == ST_IDLE) || evt_ready_i);
  assign grant_vec = grant ? (SRC_CNT'(1) << pick_id) : '0;
  assign ptr_next  = (pick_id == ID_W'(SRC_CNT - 1)) ? '0 : pick_id + ID_W'(1);

  // A new edge always wins over a grant-clear or a lost-clear.
  assign pending_d = (pending_q & ~grant_vec) | rise;
  assign lost_d    = (lost_q & ~lost_clr_i) | (rise & pending_q & ~grant_vec);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      lost_q    <= '0;
      ptr_q     <= '0;
      evt_id_q  <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      if (grant) begin
        evt_id_q <= pick_id;
        ptr_q    <= ptr_next;
      end
      case (state_q)
        ST_IDLE:  if (grant) state_q <= ST_OFFER;
        ST_OFFER: if (evt_ready_i && !grant) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign evt_valid_o = (state_q == ST_OFFER);
  assign evt_id_o    = evt_id_q;
  assign pending_o   = pending_q;
  assign lost_o      = lost_q;

endmodule

// File: tb/tb_timer_irq_sched.sv
// Directed self-checking bench for timer_irq_sched with TIMER_CNT=2
// (four sources); expected values are hand-derived cycle by cycle.
module tb_timer_irq_sched;

  logic       HCLK;
  logic       HRESET;
  logic [3:0] irq_i;
  logic [3:0] mask_i;
  logic       evt_valid_o;
  logic [1:0] evt_id_o;
  logic       evt_ready_i;
  logic [3:0] pending_o;
  logic [3:0] lost_o;
  logic [3:0] lost_clr_i;

  int checks   = 0;
  int failures = 0;

  timer_irq_sched #(.TIMER_CNT(2)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .irq_i       (irq_i),
    .mask_i      (mask_i),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_ready_i (evt_ready_i),
    .pending_o   (pending_o),
    .lost_o      (lost_o),
    .lost_clr_i  (lost_clr_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] irq, input logic [3:0] mask, input logic ready, input logic [3:0] clr);
    irq_i       = irq;
    mask_i      = mask;
    evt_ready_i = ready;
    lost_clr_i  = clr;
  endtask

  // Advance n clock edges and land 1ns past the last one, away from the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic doReset();
    HRESET = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000);
    step(2);
    HRESET = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    HRESET = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000);
    doReset();
    checkOutput("rst_valid", 32'(evt_valid_o), 32'd0);
    checkOutput("rst_id", 32'(evt_id_o), 32'd0);
    checkOutput("rst_pending", 32'(pending_o), 32'd0);
    checkOutput("rst_lost", 32'(lost_o), 32'd0);

    // Single event on source 1
    applyStimulus(4'b0010, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("single_pending", 32'(pending_o), 32'h2);
    checkOutput("single_novalid", 32'(evt_valid_o), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("single_valid", 32'(evt_valid_o), 32'd1);
    checkOutput("single_id", 32'(evt_id_o), 32'd1);
    checkOutput("single_pending_clr", 32'(pending_o), 32'd0);
    step(1);
    checkOutput("single_done", 32'(evt_valid_o), 32'd0);

    // Burst from ptr=0
    doReset();
    applyStimulus(4'b1111, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("burst_pending", 32'(pending_o), 32'hF);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("burst_id0", 32'(evt_id_o), 32'd0);
    checkOutput("burst_pend0", 32'(pending_o), 32'hE);
    step(1);
    checkOutput("burst_id1", 32'(evt_id_o), 32'd1);
    step(1);
    checkOutput("burst_id2", 32'(evt_id_o), 32'd2);
    step(1);
    checkOutput("burst_id3", 32'(evt_id_o), 32'd3);
    checkOutput("burst_valid3", 32'(evt_valid_o), 32'd1);
    checkOutput("burst_pend3", 32'(pending_o), 32'd0);
    step(1);
    checkOutput("burst_done", 32'(evt_valid_o), 32'd0);
    checkOutput("burst_lost", 32'(lost_o), 32'd0);

    // ptr wrapped to 0: sources 0 and 3 together give 0 first
    applyStimulus(4'b1001, 4'b0000, 1'b1, 4'b0000);
    step(1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("wrap_first", 32'(evt_id_o), 32'd0);
    step(1);
    checkOutput("wrap_second", 32'(evt_id_o), 32'd3);
    step(1);
    checkOutput("wrap_done", 32'(evt_valid_o), 32'd0);

    // Fairness: grant id 2 so ptr=3, then sources 1 and 3 together
    applyStimulus(4'b0100, 4'b0000, 1'b1, 4'b0000);
    step(1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("fair_id2", 32'(evt_id_o), 32'd2);
    step(1);
    applyStimulus(4'b1010, 4'b0000, 1'b1, 4'b0000);
    step(1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("fair_first", 32'(evt_id_o), 32'd3);
    step(1);
    checkOutput("fair_second", 32'(evt_id_o), 32'd1);
    checkOutput("fair_second_valid", 32'(evt_valid_o), 32'd1);
    step(1);
    checkOutput("fair_done", 32'(evt_valid_o), 32'd0);

    // Back-pressure: three pulses on source 0 with ready low
    for (int p = 0; p < 3; p++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000);
      step(1);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000);
      step(1);
    end
    checkOutput("bp_valid", 32'(evt_valid_o), 32'd1);
    checkOutput("bp_id", 32'(evt_id_o), 32'd0);
    checkOutput("bp_pending", 32'(pending_o), 32'h1);
    checkOutput("bp_lost", 32'(lost_o), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("bp_second_valid", 32'(evt_valid_o), 32'd1);
    checkOutput("bp_second_id", 32'(evt_id_o), 32'd0);
    checkOutput("bp_second_pending", 32'(pending_o), 32'd0);
    step(1);
    checkOutput("bp_done", 32'(evt_valid_o), 32'd0);
    checkOutput("bp_lost_sticky", 32'(lost_o), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0001);
    step(1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    checkOutput("bp_lost_clr", 32'(lost_o), 32'd0);

    // Mask holds source 2 pending without offering it
    applyStimulus(4'b0100, 4'b0100, 1'b1, 4'b0000);
    step(1);
    checkOutput("mask_pending", 32'(pending_o), 32'h4);
    applyStimulus(4'b0000, 4'b0100, 1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(1);
      checkOutput("mask_hold_valid", 32'(evt_valid_o), 32'd0);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("mask_drop_valid", 32'(evt_valid_o), 32'd1);
    checkOutput("mask_drop_id", 32'(evt_id_o), 32'd2);
    step(1);

    // Reset mid-offer, with irq 0 and 3 held high across reset
    applyStimulus(4'b0010, 4'b0000, 1'b0, 4'b0000);
    step(1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000);
    step(1);
    checkOutput("rmo_offer_valid", 32'(evt_valid_o), 32'd1);
    checkOutput("rmo_offer_id", 32'(evt_id_o), 32'd1);
    HRESET = 1'b1;
    applyStimulus(4'b1001, 4'b0000, 1'b0, 4'b0000);
    step(1);
    checkOutput("rmo_valid", 32'(evt_valid_o), 32'd0);
    checkOutput("rmo_id", 32'(evt_id_o), 32'd0);
    checkOutput("rmo_pending", 32'(pending_o), 32'd0);
    checkOutput("rmo_lost", 32'(lost_o), 32'd0);
    HRESET = 1'b0;
    applyStimulus(4'b1001, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("rmo_rise_pending", 32'(pending_o), 32'h9);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0000);
    step(1);
    checkOutput("rmo_first_id", 32'(evt_id_o), 32'd0);
    step(1);
    checkOutput("rmo_second_id", 32'(evt_id_o), 32'd3);
    step(1);
    checkOutput("rmo_done", 32'(evt_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_irq_sched.md
# timer_irq_sched

Interrupt scheduler for the timer bank. It collects the `2*TIMER_CNT` interrupt lines from the timers (overflow and compare per timer) and latches each rising edge as a pending event. It offers pending events one at a time, in round-robin order, to the event unit over a valid/ready handshake. It sits between the timer bank's `irq_o` bus and the SoC event unit, and tracks events lost to back-pressure.

## Interface
- `TIMER_CNT`, default 2, number of timers feeding the scheduler.
- `SRC_CNT` (localparam) = `2*TIMER_CNT`. Source `2k` is the overflow of timer k; source `2k+1` is the compare of timer k.
- `ID_W` (localparam) = `$clog2(SRC_CNT)`, minimum 1.
- `HCLK`  in  1  sole clock.
- `HRESET`  in  1  synchronous, active-high reset.
- `irq_i`  in  SRC_CNT  timer interrupt lines, directly from the timer bank.
- `mask_i`  in  SRC_CNT  1 = source is held pending and not offered.
- `evt_valid_o`  out  1  event offered.
- `evt_id_o`  out  ID_W  source index of the offered event.
- `evt_ready_i`  in  1  consumer accepts the event.
- `pending_o`  out  SRC_CNT  latched, not yet offered events.
- `lost_o`  out  SRC_CNT  sticky; an edge arrived while that source was already pending.
- `lost_clr_i`  in  SRC_CNT  clears the matching `lost_o` bits.

## Operation
- **Edge detect:** `irq_q <= irq_i`; `rise = irq_i & ~irq_q`. A level held high produces one event only.
- **Pending:** bit s is set on `rise[s]` and cleared when source s is granted. If set and clear happen in the same cycle, set wins and the new event stays pending.
- **Lost:** `lost[s]` is set when `rise[s]` occurs, `pending[s]` is already 1, and s is not granted that cycle. If `lost_clr_i[s]` and the set condition occur together, set wins.
- **Eligible set:** `pending & ~mask_i`.
- **Round-robin:**
  - Pointer `ptr` is in `0..SRC_CNT-1`.
  - The pick is the first eligible index at or above `ptr`, wrapping modulo SRC_CNT.
  - On a grant, `ptr <= (id+1) mod SRC_CNT`.
- **FSM:**
  - IDLE: when the eligible set is non-zero, grant. This registers `evt_id_o`, sets valid, clears that pending bit, and moves to OFFER.
  - OFFER: `evt_valid_o` and `evt_id_o` are held stable until `evt_ready_i`.
  - On handshake with the eligible set non-zero: grant the next source in the same cycle and stay in OFFER (back-to-back).
  - On handshake with the eligible set empty: go to IDLE.
- An offered event is never withdrawn, even if its mask bit rises while it is offered.
- `evt_ready_i` while not valid is ignored.

## Timing
- Reset values: `evt_valid_o`=0, `evt_id_o`=0, `pending_o`=0, `lost_o`=0. Internally, `ptr`=0, `irq_q`=0, state IDLE.
- Reset mid-OFFER drops the offered event, with no handshake.
- `irq_i` high across reset produces one rise on the first post-reset edge.
- Latency:
  - `irq_i` rises and is sampled at edge E.
  - `pending_o` is high after E.
  - `evt_valid_o` is high after E+1, with `pending_o` cleared at E+1, assuming the FSM is idle and no other source wins.
- Throughput is one event per cycle while `evt_ready_i`=1.
- Outputs are purely registered; there is no combinational path from `irq_i` or `evt_ready_i` to outputs.

## Structure
- Package `timer_irq_pkg` holds the state enum (IDLE, OFFER) and the source-index convention constants (`SRC_OVF`=0, `SRC_CMP`=1 within a timer pair).
- Sub-module `timer_irq_rr_pick`: combinational rotating-priority picker.
  - Inputs: eligible vector and `ptr`.
  - Outputs: `found` and `id`.
  - Reusable by other event arbiters.
- Top level holds the edge detect, the pending/lost registers, the FSM, and the output registers.

## Test plan
- **Single event:** TIMER_CNT=2, `evt_ready_i`=1, pulse `irq_i[1]` sampled at edge 5 → `pending_o`=4'b0010 after edge 5; `evt_valid_o`=1 with `evt_id_o`=1 after edge 6 for one cycle; `pending_o`=0.
- **Burst:** `irq_i`=4'b1111 for one cycle, ready=1 → ids 0,1,2,3 on four consecutive cycles; ptr ends at 0; no lost bits.
- **Fairness:** after id 2 is granted (ptr=3), sources 1 and 3 pulse together → id 3 first, then id 1.
- **Back-pressure and lost:** ready=0, three separate pulses on source 0 →
  - `evt_id_o`=0 held valid, `pending_o[0]`=1, `lost_o[0]`=1.
  - Raise ready → second event delivered.
  - `lost_clr_i[0]` pulse → `lost_o[0]`=0.
- **Mask:** `mask_i[2]`=1, pulse source 2 → `pending_o[2]`=1, no valid for 10 cycles. Drop the mask → valid with id 2 one cycle later.
- **Reset mid-offer:** assert HRESET while valid (ready=0) → after the edge all outputs are 0. A new pulse on source 3 is then granted before source 0 only if 0 is not pending; this confirms ptr=0.
